// File: rtl/seg7_decode_monitor.sv
// Seven-segment read-back monitor: waits for a stable segment pattern,
// decodes it to a hex digit, flags illegal patterns and counts new digits.
// Optional build macro: SEG7_ERRCNT_EN adds err_count (illegal-lock counter).
module seg7_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       valid,
  output logic       bad,
  output logic       new_pulse,
  output logic [7:0] lock_count
`ifdef SEG7_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_AT = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [6:0]       s0;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       prev_digit;
  logic             have_prev;

  logic [6:0] lit_c;
  logic       changed_c;
  logic       lock_c;
  logic       legal_c;
  logic [3:0] digit_c;
  logic       pulse_c;

  // Normalise the bus so a lit segment is always a 1.
  assign lit_c     = ACTIVE_LOW ? ~seg : seg;
  assign changed_c = (lit_c != s0);
  assign lock_c    = !changed_c && (state != LOCKED) && (cnt == LOCK_AT);
  assign pulse_c   = legal_c && (!have_prev || (digit_c != prev_digit));

  // Reverse segment decode (gfedcba, active-high) back to a hex digit.
  always_comb begin
    legal_c = 1'b1;
    digit_c = 4'h0;
    case (lit_c)
      7'b0111111: digit_c = 4'h0;
      7'b0000110: digit_c = 4'h1;
      7'b1011011: digit_c = 4'h2;
      7'b1001111: digit_c = 4'h3;
      7'b1100110: digit_c = 4'h4;
      7'b1101101: digit_c = 4'h5;
      7'b1111101: digit_c = 4'h6;
      7'b0000111: digit_c = 4'h7;
      7'b1111111: digit_c = 4'h8;
      7'b1101111: digit_c = 4'h9;
      7'b1110111: digit_c = 4'hA;
      7'b1111100: digit_c = 4'hB;
      7'b0111001: digit_c = 4'hC;
      7'b1011110: digit_c = 4'hD;
      7'b1111001: digit_c = 4'hE;
      7'b1110001: digit_c = 4'hF;
      default:    legal_c = 1'b0;
    endcase
  end

  // Next-state: any input change restarts settling; lock after the stable run.
  always_comb begin
    state_next = state;
    if (changed_c) begin
      state_next = SETTLING;
    end else if (lock_c) begin
      state_next = LOCKED;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UNLOCKED;
    end else begin
      state <= state_next;
    end
  end

  // Sample/stability counter and registered lock outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0         <= 7'd0;
      cnt        <= '0;
      hex        <= 4'h0;
      valid      <= 1'b0;
      bad        <= 1'b0;
      new_pulse  <= 1'b0;
      lock_count <= 8'd0;
      prev_digit <= 4'h0;
      have_prev  <= 1'b0;
`ifdef SEG7_ERRCNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      new_pulse <= 1'b0;
      if (changed_c) begin
        s0    <= lit_c;
        cnt   <= '0;
        valid <= 1'b0;
        bad   <= 1'b0;
      end else if (lock_c) begin
        cnt <= CNT_MAX;
        if (legal_c) begin
          valid      <= 1'b1;
          bad        <= 1'b0;
          hex        <= digit_c;
          prev_digit <= digit_c;
          have_prev  <= 1'b1;
          if (pulse_c) begin
            new_pulse <= 1'b1;
            if (lock_count != 8'hFF) begin
              lock_count <= lock_count + 8'd1;
            end
          end
        end else begin
          valid <= 1'b0;
          bad   <= 1'b1;
`ifdef SEG7_ERRCNT_EN
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
`endif
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Scoreboard bench for seg7_decode_monitor: stimulus pushes expected lock
// events, a negedge monitor pops and compares them when valid/bad rises.
module tb_seg7_decode_monitor;

  localparam int unsigned STABLE = 4;
  localparam bit          ACT_LO = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = 7'd0;
  logic [3:0] hex;
  logic       valid;
  logic       bad;
  logic       new_pulse;
  logic [7:0] lock_count;
`ifdef SEG7_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seg7_decode_monitor #(
    .STABLE_CYCLES(STABLE),
    .ACTIVE_LOW   (ACT_LO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .hex       (hex),
    .valid     (valid),
    .bad       (bad),
    .new_pulse (new_pulse),
    .lock_count(lock_count)
`ifdef SEG7_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Active-high gfedcba patterns for 0..F.
  logic [6:0] pat [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct {
    int         cyc;
    logic [3:0] hex;
    logic       valid;
    logic       bad;
    logic       pulse;
    logic [7:0] lcnt;
    logic [7:0] ecnt;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  logic prev_vb = 1'b0;

  // Reference model state.
  logic [3:0] m_hex;
  logic       m_have;
  logic [3:0] m_prev;
  logic [7:0] m_lcnt;
  logic [7:0] m_ecnt;
  logic [6:0] last_lit;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lookup(input logic [6:0] lit);
    for (int i = 0; i < 16; i++) begin
      if (pat[i] == lit) return i;
    end
    return -1;
  endfunction

  // Drive an active-high pattern for n edges, queueing the lock it should cause.
  task automatic apply(input logic [6:0] lit, input int n);
    exp_t e;
    bit   chg;
    int   d;
    chg = (lit != last_lit);
    seg = ACT_LO ? ~lit : lit;
    if (chg && n >= int'(STABLE) + 1) begin
      d = lookup(lit);
      e.cyc = cyc + int'(STABLE) + 1;
      if (d >= 0) begin
        e.pulse = !m_have || (4'(d) != m_prev);
        if (e.pulse && m_lcnt != 8'hFF) m_lcnt = m_lcnt + 8'd1;
        m_hex  = 4'(d);
        m_prev = 4'(d);
        m_have = 1'b1;
        e.valid = 1'b1;
        e.bad   = 1'b0;
      end else begin
        e.pulse = 1'b0;
        e.valid = 1'b0;
        e.bad   = 1'b1;
        if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      end
      e.hex  = m_hex;
      e.lcnt = m_lcnt;
      e.ecnt = m_ecnt;
      q.push_back(e);
    end
    last_lit = lit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0 && chg) chk("drop_on_change", {30'd0, valid, bad}, 32'd0);
    end
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    repeat (k) @(negedge clk);
    chk("rst_hex", 32'(hex), 32'd0);
    chk("rst_valid_bad_pulse", {29'd0, valid, bad, new_pulse}, 32'd0);
    chk("rst_lock_count", 32'(lock_count), 32'd0);
`ifdef SEG7_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;
    m_hex = 4'h0; m_have = 1'b0; m_prev = 4'h0;
    m_lcnt = 8'd0; m_ecnt = 8'd0; last_lit = 7'd0;
  endtask

  // Monitor: a rising valid|bad is a lock event; compare it with the queue head.
  always @(negedge clk) begin
    logic vb;
    exp_t e;
    if (mon_en) begin
      vb = valid | bad;
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL lock_missing: no lock seen, expected at cycle %0d hex %0h", e.cyc, e.hex);
      end
      if (vb === 1'b1 && prev_vb !== 1'b1) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_lock: hex %0h valid %b bad %b at cycle %0d", hex, valid, bad, cyc);
        end else begin
          e = q.pop_front();
          chk("lock_cycle", 32'(cyc), 32'(e.cyc));
          chk("lock_hex", 32'(hex), 32'(e.hex));
          chk("lock_valid_bad", {30'd0, valid, bad}, {30'd0, e.valid, e.bad});
          chk("lock_new_pulse", 32'(new_pulse), 32'(e.pulse));
          chk("lock_count", 32'(lock_count), 32'(e.lcnt));
`ifdef SEG7_ERRCNT_EN
          chk("err_count", 32'(err_count), 32'(e.ecnt));
`endif
        end
      end else begin
        chk("new_pulse_idle", 32'(new_pulse), 32'd0);
      end
      prev_vb = vb;
    end
  end

  initial begin
    @(negedge clk);
    do_reset(3);
    mon_en = 1'b1;

    // Digit 0 held, then a 2-cycle glitch to 1 and back: relock without pulse.
    apply(pat[0], 10);
    apply(pat[1], 2);
    apply(pat[0], 6);

    // Full sweep 0..F.
    for (int d = 0; d < 16; d++) apply(pat[d], 6);

    // Illegal patterns after digit 5; a second illegal lock counts again.
    apply(pat[5], 6);
    apply(7'b0000001, 6);
    apply(7'b0000011, 6);

    // Change on the would-be lock edge: 7 must not lock, 8 must.
    apply(pat[7], 4);
    apply(pat[8], 6);

    // Reset mid-settle on 3, then a full-length lock on 3.
    apply(pat[3], 2);
    do_reset(2);
    apply(pat[3], 6);

    // 300 alternating locks saturate lock_count.
    for (int i = 0; i < 300; i++) apply((i % 2 == 0) ? pat[1] : pat[2], 5);
    repeat (3) @(negedge clk);
    chk("lock_count_saturated", 32'(lock_count), 32'd255);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
